imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory's byte-enabled write port (port A).
- Accepts a byte stream (valid/ready) from the debug UART receiver, parses a 4-byte little-endian length header, then packs payload bytes into 32-bit little-endian words.
- Each word is written with registered ena/wea/addr/data, and a short final word is written with a partial byte mask.
- The CPU fetch path reads the same memory through port B; the loader only drives port A.

Parameters:
- BASE_ADDR, 0, byte address of the first payload byte. Must be word-aligned and below MEM_BYTES.
- MEM_BYTES, 16384, memory capacity in bytes. Sets the overflow check; the address is 14 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that arms the loader; ignored unless in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_ena  output  1  port A enable.
- imem_wea  output  4  port A byte write enables; bit i covers dina[8i+7:8i].
- imem_addra  output  14  port A byte address, always word-aligned ([1:0]=0).
- imem_dina  output  32  port A write data.
- busy  output  1  high in LEN, DATA and FLUSH.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky overflow flag; cleared by the next accepted start.
- byte_cnt  output  15  payload bytes accepted so far in the current load.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. in_ready, imem_ena, imem_wea, imem_addra, imem_dina, busy, done, err and byte_cnt are all 0; the internal length and shift registers are 0.
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_ready is a registered output, high only in LEN and DATA. At most one byte is accepted per cycle.
- IDLE:
  - start=1 → LEN; header count=0, err=0, byte_cnt=0, word address=BASE_ADDR.
- LEN:
  - Accepts 4 bytes into len[31:0], first byte into len[7:0].
  - On the 4th byte, if len > MEM_BYTES-BASE_ADDR: err=1, → IDLE. The payload is not consumed and done is not pulsed.
  - Else if len==0: done pulses, → IDLE.
  - Else → DATA.
- DATA:
  - Each accepted byte is placed in lane k = byte_cnt[1:0], and byte_cnt increments.
  - When lane 3 fills, the next cycle shows imem_ena=1, imem_wea=4'hF, imem_addra=current word address, imem_dina=assembled word. The word address then advances by 4.
  - When byte_cnt reaches len after the byte is accepted:
    - If the last lane is 3, the full-word write above is the final write.
    - Otherwise → FLUSH.
    - In both cases done pulses in the cycle after the final write strobe.
- FLUSH:
  - One cycle with imem_ena=1 and imem_wea = mask of the filled lanes: 4'h1, 4'h3 or 4'h7 for 1, 2 or 3 bytes.
  - Unfilled data lanes are driven 0. in_ready=0.
  - Then done pulses and → IDLE.
- Write strobe: imem_ena/imem_wea are high for exactly one cycle per word and are 0 in every other cycle. imem_addra and imem_dina hold their last value between writes.
- Latency: the write strobe appears 1 cycle after the edge that accepts the completing byte. in_ready may stay high during that cycle, because the next word's lanes are separate from the output register.
- start in any state other than IDLE is ignored; busy stays 1.
- byte_cnt holds its final value in IDLE until the next accepted start.
- Address wrap is impossible: the overflow check guarantees the last address is at most MEM_BYTES-4.
- Reset mid-load returns to IDLE immediately. Words already written remain in memory, and no done pulse occurs.

Test Plan:
- Reset, then start; stream 08 00 00 00, 11 22 33 44, 55 66 77 88 with in_valid continuous → writes addr 0x0000 wea F dina 0x44332211, then addr 0x0004 wea F dina 0x88776655; done pulses once; byte_cnt=8; err=0.
- Length 6, payload AA BB CC DD EE FF → second write at addr 0x0004 with wea 4'h3 and dina 0x0000FFEE; done follows the FLUSH cycle.
- Header 01 40 00 00 (0x4001 > 16384) → err=1, back in IDLE, in_ready=0, no imem_ena; the next start clears err.
- Length 0 → no writes, done pulses after the 4th header byte.
- in_valid toggled randomly (about 50%) during a 13-byte load → identical memory contents to the continuous case; exactly 4 write strobes (3 full, final wea 4'h1).
- rst_n asserted after 5 payload bytes → all outputs 0 at once, state IDLE; a subsequent full load works and starts at BASE_ADDR. Also: start pulses during DATA are ignored.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: parses a 4-byte LE length header from a byte stream, then packs payload into 32-bit LE words on port A.
// Latency: each word write strobe appears 1 cycle after the edge accepting its last byte; done follows the final strobe by 1 cycle.
// Backpressure: in_ready is registered, high only while parsing the header or payload; at most one byte per cycle.
module imem_loader #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_ena,
  output logic [3:0]  imem_wea,
  output logic [13:0] imem_addra,
  output logic [31:0] imem_dina,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] byte_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH} state_t;

  // Room left between the load base and the top of memory.
  localparam logic [31:0] CAP  = 32'(MEM_BYTES - BASE_ADDR);
  localparam logic [13:0] BASE = 14'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [13:0] addr_q, addr_d;
  logic [14:0] byte_cnt_q, byte_cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        ena_q, ena_d;
  logic [3:0]  wea_q, wea_d;
  logic [13:0] addra_q, addra_d;
  logic [31:0] dina_q, dina_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [31:0] hdr_len;
  logic [1:0]  lane;
  logic [31:0] word_new;
  logic [14:0] cnt_next;
  logic        last_byte;

  assign accept  = in_valid & in_ready_q;
  // Full length as it will look once the 4th header byte lands.
  assign hdr_len = {in_data, len_q[23:0]};
  assign lane    = byte_cnt_q[1:0];

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    err_d      = err_q;
    ena_d      = 1'b0;
    wea_d      = 4'h0;
    done_d     = 1'b0;

    // Current word with the incoming byte dropped into its lane; lanes
    // above it are still zero because the word is cleared after each write.
    word_new = word_q;
    word_new[{lane, 3'b000} +: 8] = in_data;
    cnt_next  = byte_cnt_q + 15'd1;
    last_byte = ({17'd0, cnt_next} == len_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN;
          hdr_cnt_d  = 2'd0;
          len_d      = 32'd0;
          word_d     = 32'd0;
          addr_d     = BASE;
          byte_cnt_d = 15'd0;
          err_d      = 1'b0;
        end
      end

      S_LEN: begin
        if (accept) begin
          len_d[{hdr_cnt_q, 3'b000} +: 8] = in_data;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (hdr_len > CAP) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (hdr_len == 32'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_cnt_d = cnt_next;
          if (lane == 2'd3 || last_byte) begin
            // Word complete (or stream ended mid-word): launch the write.
            ena_d   = 1'b1;
            addra_d = addr_q;
            dina_d  = word_new;
            word_d  = 32'd0;
            addr_d  = addr_q + 14'd4;
            case (lane)
              2'd0:    wea_d = 4'h1;
              2'd1:    wea_d = 4'h3;
              2'd2:    wea_d = 4'h7;
              default: wea_d = 4'hF;
            endcase
          end else begin
            word_d = word_new;
          end
          // FLUSH is the cycle the final strobe is visible; done follows it.
          if (last_byte) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d     = in_ready_d || (state_d == S_FLUSH);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= 2'd0;
      len_q      <= 32'd0;
      word_q     <= 32'd0;
      addr_q     <= 14'd0;
      byte_cnt_q <= 15'd0;
      in_ready_q <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 4'h0;
      addra_q    <= 14'd0;
      dina_q     <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      in_ready_q <= in_ready_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_ena   = ena_q;
  assign imem_wea   = wea_q;
  assign imem_addra = addra_q;
  assign imem_dina  = dina_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, model-checked random loads,
// and hand sequences for mid-load start and reset.
module tb_imem_loader;
  localparam int BASE = 0;
  localparam int MEMB = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_ena;
  logic [3:0]  imem_wea;
  logic [13:0] imem_addra;
  logic [31:0] imem_dina;
  logic        busy;
  logic        done;
  logic        err;
  logic [14:0] byte_cnt;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_ena(imem_ena), .imem_wea(imem_wea), .imem_addra(imem_addra),
    .imem_dina(imem_dina), .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay [0:MEMB-1];
  logic [7:0] mem [0:MEMB-1];

  // Monitor state (written only by the monitor process).
  logic        mon_clr = 1'b0;
  int          cyc = 0;
  int          strobes = 0;
  int          done_n = 0;
  int          viol = 0;
  int          last_acc = -1;
  int          last_strobe = -1;
  int          done_cyc = -1;
  logic [3:0]  last_wea = '0;
  logic [13:0] last_addr = '0;
  logic [13:0] first_addr = '0;
  logic [31:0] last_dina = '0;

  // Port-A memory model plus strobe/done bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      strobes = 0; done_n = 0; last_acc = -1; last_strobe = -1; done_cyc = -1;
      for (int i = 0; i < MEMB; i++) mem[i] = 8'hC3;
    end else if (rst_n) begin
      if (in_valid && in_ready) last_acc = cyc;
      if ((imem_ena == 1'b0) != (imem_wea == 4'h0) || imem_addra[1:0] != 2'b00) viol++;
      if (imem_ena) begin
        strobes++;
        if (strobes == 1) first_addr = imem_addra;
        last_strobe = cyc;
        last_wea = imem_wea; last_addr = imem_addra; last_dina = imem_dina;
        for (int b = 0; b < 4; b++)
          if (imem_wea[b]) mem[int'(imem_addra) + b] = imem_dina[8*b +: 8];
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    align();
    start = 1'b0;
  endtask

  // Offer one byte, randomly withholding valid gap_pct% of cycles.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit took;
    for (int t = 0; t < 400; t++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      took = in_valid && in_ready;
      align();
      if (took) return;
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic run_load(input logic [31:0] hdr, input int npay, input int gap);
    int t;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    align();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], gap);
    for (int i = 0; i < npay; i++) send_byte(pay[i], gap);
    in_valid = 1'b0;
    t = 0;
    while (busy && t < 100) begin
      align();
      t++;
    end
    if (busy) chk("busy_timeout", 1, 0);
    repeat (3) align();
  endtask

  task automatic check_load(input string nm, input int len, input int exp_str,
                            input logic [3:0] exp_wea, input logic [13:0] exp_addr,
                            input logic [31:0] exp_dina, input bit exp_err, input int exp_done);
    int errs;
    int lim;
    chk({nm, ".strobes"}, strobes, exp_str);
    chk({nm, ".err"}, err, exp_err);
    chk({nm, ".done_n"}, done_n, exp_done);
    chk({nm, ".byte_cnt"}, byte_cnt, exp_err ? 0 : len);
    chk({nm, ".in_ready"}, in_ready, 0);
    chk({nm, ".busy"}, busy, 0);
    if (exp_str > 0) begin
      chk({nm, ".wea"}, last_wea, exp_wea);
      chk({nm, ".addr"}, last_addr, exp_addr);
      chk({nm, ".dina"}, last_dina, exp_dina);
      chk({nm, ".first_addr"}, first_addr, BASE);
      chk({nm, ".strobe_lat"}, last_strobe - last_acc, 1);
      chk({nm, ".done_lat"}, done_cyc - last_strobe, 1);
    end else if (exp_done > 0) begin
      chk({nm, ".done_lat0"}, done_cyc - last_acc, 1);
    end
    errs = 0;
    lim = (exp_err ? 0 : len) + BASE + 4;
    if (lim > MEMB) lim = MEMB;
    for (int i = 0; i < lim; i++) begin
      if (i >= BASE && i < BASE + (exp_err ? 0 : len)) begin
        if (mem[i] !== pay[i - BASE]) errs++;
      end else if (mem[i] !== 8'hC3) begin
        errs++;
      end
    end
    chk({nm, ".mem_errs"}, errs, 0);
  endtask

  // Reference model: expectations derived from the length and payload alone.
  task automatic model_load(input string nm, input int len, input int gap);
    int          r;
    int          wbase;
    logic [3:0]  ewea;
    logic [31:0] edina;
    r     = len % 4;
    ewea  = (r == 0) ? 4'hF : 4'((1 << r) - 1);
    wbase = 4 * ((len - 1) / 4);
    edina = '0;
    for (int b = 0; b < 4; b++)
      if (wbase + b < len) edina[8*b +: 8] = pay[wbase + b];
    run_load(32'(len), len, gap);
    check_load(nm, len, (len + 3) / 4, ewea, 14'(BASE + wbase), edina, 1'b0, 1);
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          npay;
    logic [7:0]  p0;
    int          exp_str;
    logic [3:0]  exp_wea;
    logic [13:0] exp_addr;
    logic [31:0] exp_dina;
    bit          exp_err;
    int          exp_done;
    int          gap;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{32'd8,          8,     8'h11, 2,    4'hF, 14'h0004, 32'h88776655, 1'b0, 1, 0};
    vecs[1] = '{32'd6,          6,     8'hAA, 2,    4'h3, 14'h0004, 32'h0000FFEE, 1'b0, 1, 0};
    vecs[2] = '{32'h00004001,   0,     8'h00, 0,    4'h0, 14'h0000, 32'h0,        1'b1, 0, 0};
    vecs[3] = '{32'd0,          0,     8'h00, 0,    4'h0, 14'h0000, 32'h0,        1'b0, 1, 0};
    vecs[4] = '{32'd1,          1,     8'h5A, 1,    4'h1, 14'h0000, 32'h0000005A, 1'b0, 1, 25};
    vecs[5] = '{32'd3,          3,     8'h01, 1,    4'h7, 14'h0000, 32'h00231201, 1'b0, 1, 0};
    vecs[6] = '{32'd4,          4,     8'hF0, 1,    4'hF, 14'h0000, 32'h231201F0, 1'b0, 1, 40};
    vecs[7] = '{32'hFFFFFFFF,   0,     8'h00, 0,    4'h0, 14'h0000, 32'h0,        1'b1, 0, 0};
    vecs[8] = '{32'd16384,      16384, 8'h00, 4096, 4'hF, 14'h3FFC, 32'hEFDECDBC, 1'b0, 1, 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.ena", imem_ena, 0);
    chk("rst.wea", imem_wea, 0);
    chk("rst.addra", imem_addra, 0);
    chk("rst.dina", imem_dina, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.byte_cnt", byte_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    align();

    // Directed table.
    foreach (vecs[v]) begin
      for (int i = 0; i < MEMB; i++) pay[i] = 8'(vecs[v].p0 + 8'(17 * i));
      run_load(vecs[v].hdr, vecs[v].npay, vecs[v].gap);
      check_load($sformatf("vec%0d", v), vecs[v].npay, vecs[v].exp_str, vecs[v].exp_wea,
                 vecs[v].exp_addr, vecs[v].exp_dina, vecs[v].exp_err, vecs[v].exp_done);
    end

    // Overflow leaves err set until a new start is accepted.
    run_load(32'h00004001, 0, 0);
    chk("ovf.err_set", err, 1);
    pulse_start();
    chk("ovf.err_clr", err, 0);
    chk("ovf.busy", busy, 1);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
    in_valid = 1'b0;
    repeat (3) align();
    chk("ovf.idle_after_len0", busy, 0);

    // 13-byte load, continuous then with ~50% valid gaps, same payload.
    for (int i = 0; i < 13; i++) pay[i] = 8'($urandom);
    model_load("r13_cont", 13, 0);
    model_load("r13_gap", 13, 50);
    chk("r13_gap.strobes4", strobes, 4);
    chk("r13_gap.wea1", last_wea, 4'h1);

    // Random lengths and payloads.
    for (int n = 0; n < 6; n++) begin
      int len;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      model_load($sformatf("rnd%0d", n), len, int'($urandom_range(0, 60)));
    end

    // Start during DATA is ignored; reset mid-load clears everything at once.
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    align();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 20 : 0), 0);
    for (int i = 0; i < 3; i++) send_byte(pay[i], 0);
    in_valid = 1'b0;
    pulse_start();
    chk("mid.busy", busy, 1);
    chk("mid.in_ready", in_ready, 1);
    chk("mid.byte_cnt", byte_cnt, 3);
    for (int i = 3; i < 5; i++) send_byte(pay[i], 0);
    in_valid = 1'b0;
    chk("mid.byte_cnt5", byte_cnt, 5);
    chk("mid.strobes", strobes, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", in_ready, 0);
    chk("mrst.ena", imem_ena, 0);
    chk("mrst.wea", imem_wea, 0);
    chk("mrst.addra", imem_addra, 0);
    chk("mrst.dina", imem_dina, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.done", done, 0);
    chk("mrst.err", err, 0);
    chk("mrst.byte_cnt", byte_cnt, 0);
    #2 rst_n = 1'b1;
    align();
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    model_load("after_rst", 8, 30);

    chk("strobe_format_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
